// File: rtl/axis_packet_mux.sv
// Packet-atomic N:1 AXI-Stream mux: external select or round-robin, registered output.
// Latency: grant registered one edge after request, first beat on the output one edge later.
// Backpressure: granted s_tready = !m_tvalid | m_tready; other readies low; output held while stalled.
//
// Ports:
//   clk, reset          - single clock, asynchronous active-high reset
//   s_tdata/tvalid/tlast - NUM_CH packed input streams, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tready            - per-channel ready, at most one bit high (granted channel only)
//   sel                 - requested channel when MODE == 0, ignored when MODE == 1
//   m_tdata/tvalid/tlast/tready - registered output stream
//   grant, busy         - current/most recent grant; high while a packet is in flight
//   pkt_count           - packets whose tlast beat was accepted, wraps
module axis_packet_mux #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 4,
    parameter int MODE       = 0,
    parameter int CNT_WIDTH  = 16,
    localparam int SEL_W     = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH-1:0]            s_tvalid,
    input  logic [NUM_CH-1:0]            s_tlast,
    output logic [NUM_CH-1:0]            s_tready,
    input  logic [SEL_W-1:0]             sel,
    output logic [DATA_WIDTH-1:0]        m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    output logic [SEL_W-1:0]             grant,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         pkt_count
);

    // Valid/last padded to the full select range so an out-of-range
    // select or grant index always reads a defined zero.
    localparam int PAD_W = 1 << SEL_W;

    typedef enum logic {IDLE, PKT} state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     grant_q, grant_d;
    logic [SEL_W-1:0]     last_q;
    logic [PAD_W-1:0]     tvalid_pad;
    logic [PAD_W-1:0]     tlast_pad;
    logic                 out_rdy;
    logic                 accept;
    logic                 pkt_done;
    logic                 rr_found;
    logic [SEL_W-1:0]     rr_idx;

    assign grant = grant_q;
    assign busy  = (state_q == PKT);

    always_comb begin
        tvalid_pad = PAD_W'(s_tvalid);
        tlast_pad  = PAD_W'(s_tlast);
        // The output register can take a new beat if it is empty or draining now.
        out_rdy    = !m_tvalid | m_tready;

        // Round-robin search starts just after the last channel served.
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (!rr_found && tvalid_pad[SEL_W'((int'(last_q) + i) % NUM_CH)]) begin
                rr_found = 1'b1;
                rr_idx   = SEL_W'((int'(last_q) + i) % NUM_CH);
            end
        end

        state_d  = state_q;
        grant_d  = grant_q;
        s_tready = '0;
        accept   = 1'b0;
        pkt_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (MODE == 0) begin
                    if ((int'(sel) < NUM_CH) && tvalid_pad[sel]) begin
                        grant_d = sel;
                        state_d = PKT;
                    end
                end else if (rr_found) begin
                    grant_d = rr_idx;
                    state_d = PKT;
                end
            end
            PKT: begin
                s_tready = NUM_CH'(out_rdy) << grant_q;
                accept   = tvalid_pad[grant_q] & out_rdy;
                if (accept && tlast_pad[grant_q]) begin
                    pkt_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= SEL_W'(NUM_CH - 1);
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            pkt_count <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (accept) begin
                // Reload covers the simultaneous drain case with no bubble.
                m_tdata  <= s_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                m_tlast  <= tlast_pad[grant_q];
                m_tvalid <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
            if (pkt_done) begin
                last_q    <= grant_q;
                pkt_count <= pkt_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_packet_mux.sv
// Bench for axis_packet_mux: select-mode, round-robin and out-of-range-select instances.
// Sources are queue-driven AXI-Stream models; a negedge monitor pops an expected-beat scoreboard.
// Directed scenarios cover latency, packet atomicity, stalls, round-robin order and mid-packet reset.
module tb_axis_packet_mux;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic clk;
    logic reset;

    // Index 0: MODE 0 instance, index 1: MODE 1 instance (both 4 channels).
    logic [1:0][63:0] s_tdata;
    logic [1:0][3:0]  s_tvalid;
    logic [1:0][3:0]  s_tlast;
    logic [1:0][3:0]  s_tready;
    logic [1:0][1:0]  sel;
    logic [1:0][15:0] m_tdata;
    logic [1:0]       m_tvalid;
    logic [1:0]       m_tlast;
    logic [1:0]       m_tready;
    logic [1:0][1:0]  grant;
    logic [1:0]       busy;
    logic [1:0][15:0] pkt_count;

    // Three-channel select-mode instance driven with an out-of-range select.
    logic [47:0] s_tdata2;
    logic [2:0]  s_tvalid2, s_tlast2, s_tready2;
    logic [1:0]  sel2, grant2;
    logic [15:0] m_tdata2, pkt_count2;
    logic        m_tvalid2, m_tlast2, m_tready2, busy2;

    beat_t src_q[8][$];
    beat_t exp_q[2][$];
    logic [7:0]       acc;
    logic [1:0]       stall_prev;
    logic [1:0][15:0] prev_dat;
    logic [1:0]       prev_last;

    int n_checks = 0;
    int n_fail   = 0;

    axis_packet_mux #(.DATA_WIDTH(16), .NUM_CH(4), .MODE(0), .CNT_WIDTH(16)) u_sel (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata[0]), .s_tvalid(s_tvalid[0]), .s_tlast(s_tlast[0]), .s_tready(s_tready[0]),
        .sel(sel[0]),
        .m_tdata(m_tdata[0]), .m_tvalid(m_tvalid[0]), .m_tlast(m_tlast[0]), .m_tready(m_tready[0]),
        .grant(grant[0]), .busy(busy[0]), .pkt_count(pkt_count[0])
    );

    axis_packet_mux #(.DATA_WIDTH(16), .NUM_CH(4), .MODE(1), .CNT_WIDTH(16)) u_rr (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata[1]), .s_tvalid(s_tvalid[1]), .s_tlast(s_tlast[1]), .s_tready(s_tready[1]),
        .sel(sel[1]),
        .m_tdata(m_tdata[1]), .m_tvalid(m_tvalid[1]), .m_tlast(m_tlast[1]), .m_tready(m_tready[1]),
        .grant(grant[1]), .busy(busy[1]), .pkt_count(pkt_count[1])
    );

    axis_packet_mux #(.DATA_WIDTH(16), .NUM_CH(3), .MODE(0), .CNT_WIDTH(16)) u_oor (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata2), .s_tvalid(s_tvalid2), .s_tlast(s_tlast2), .s_tready(s_tready2),
        .sel(sel2),
        .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tlast(m_tlast2), .m_tready(m_tready2),
        .grant(grant2), .busy(busy2), .pkt_count(pkt_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_checks++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, ex, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int d, input int ch, input logic [15:0] dat, input logic last);
        beat_t b;
        b.d = dat;
        b.l = last;
        src_q[d*4 + ch].push_back(b);
        exp_q[d].push_back(b);
    endtask

    task automatic wait_empty(input int d, input int lim);
        int n = 0;
        while (exp_q[d].size() != 0 && n < lim) begin
            step();
            n++;
        end
        chk("scoreboard_drained", exp_q[d].size(), 0);
    endtask

    // Source models: present the queue head; pop it on the edge after a handshake.
    initial begin
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        forever begin
            @(posedge clk);
            for (int k = 0; k < 8; k++)
                if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            #1;
            for (int k = 0; k < 8; k++) begin
                if (src_q[k].size() > 0) begin
                    s_tvalid[k/4][k%4]           = 1'b1;
                    s_tdata[k/4][(k%4)*16 +: 16] = src_q[k][0].d;
                    s_tlast[k/4][k%4]            = src_q[k][0].l;
                end else begin
                    s_tvalid[k/4][k%4] = 1'b0;
                    s_tlast[k/4][k%4]  = 1'b0;
                end
            end
        end
    end

    // Monitor: record input handshakes, check ready rules, stability and output beats.
    initial begin
        acc        = '0;
        stall_prev = '0;
        prev_dat   = '0;
        prev_last  = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < 4; ch++)
                    acc[d*4 + ch] = s_tvalid[d][ch] & s_tready[d][ch];
                if (reset) begin
                    stall_prev[d] = 1'b0;
                end else begin
                    chk("tready_onehot", 32'($countones(s_tready[d]) <= 1), 1);
                    chk("tready_ungranted", s_tready[d] & ~(4'b0001 << grant[d]), 0);
                    if (stall_prev[d]) begin
                        chk("stall_tvalid", m_tvalid[d], 1);
                        chk("stall_tdata", m_tdata[d], prev_dat[d]);
                        chk("stall_tlast", m_tlast[d], prev_last[d]);
                    end
                    if (m_tvalid[d] && !m_tready[d])
                        chk("stall_s_tready", s_tready[d], 0);
                    if (m_tvalid[d] && m_tready[d]) begin
                        if (exp_q[d].size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL out_beat: got unexpected beat %0h on dut %0d, expected none", m_tdata[d], d);
                        end else begin
                            beat_t e;
                            e = exp_q[d].pop_front();
                            chk("out_tdata", m_tdata[d], e.d);
                            chk("out_tlast", m_tlast[d], e.l);
                        end
                    end
                    stall_prev[d] = m_tvalid[d] & !m_tready[d];
                    prev_dat[d]   = m_tdata[d];
                    prev_last[d]  = m_tlast[d];
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        sel       = '0;
        sel[0]    = 2'd1;
        m_tready  = 2'b11;
        sel2      = 2'd3;
        s_tvalid2 = 3'b111;
        s_tlast2  = 3'b111;
        s_tdata2  = 48'h3333_2222_1111;
        m_tready2 = 1'b1;
        #12;
        for (int d = 0; d < 2; d++) begin
            chk("rst_m_tvalid", m_tvalid[d], 0);
            chk("rst_m_tdata", m_tdata[d], 0);
            chk("rst_m_tlast", m_tlast[d], 0);
            chk("rst_grant", grant[d], 0);
            chk("rst_busy", busy[d], 0);
            chk("rst_pkt_count", pkt_count[d], 0);
            chk("rst_s_tready", s_tready[d], 0);
        end
        step();
        reset = 1'b0;

        // Select mode: three-beat packet from channel 1 with exact latency.
        @(posedge clk);
        push(0, 1, 16'h2345, 1'b0);
        push(0, 1, 16'h8962, 1'b0);
        push(0, 1, 16'hABCD, 1'b1);
        step();
        chk("t1_busy_grant_edge", busy[0], 1);
        chk("t1_grant", grant[0], 1);
        chk("t1_no_output_yet", m_tvalid[0], 0);
        step();
        chk("t1_beat1_vld", m_tvalid[0], 1);
        chk("t1_beat1_dat", m_tdata[0], 16'h2345);
        step();
        chk("t1_beat2_dat", m_tdata[0], 16'h8962);
        step();
        chk("t1_beat3_dat", m_tdata[0], 16'hABCD);
        chk("t1_beat3_last", m_tlast[0], 1);
        chk("t1_idle_after_last", busy[0], 0);
        chk("t1_pkt_count", pkt_count[0], 1);
        wait_empty(0, 20);
        chk("oor_m_tvalid_mid", m_tvalid2, 0);
        chk("oor_busy_mid", busy2, 0);

        // Select changes mid-packet: channel 1 packet completes before channel 2.
        @(posedge clk);
        push(0, 1, 16'h1111, 1'b0);
        push(0, 1, 16'h1112, 1'b0);
        push(0, 1, 16'h1113, 1'b0);
        push(0, 1, 16'h1114, 1'b1);
        push(0, 2, 16'h2221, 1'b0);
        push(0, 2, 16'h2222, 1'b1);
        step();
        chk("t2_grant_ch1", grant[0], 1);
        step();
        step();
        sel[0] = 2'd2;
        step();
        step();
        chk("t2_idle_gap", busy[0], 0);
        chk("t2_grant_held", grant[0], 1);
        step();
        chk("t2_busy_ch2", busy[0], 1);
        chk("t2_grant_ch2", grant[0], 2);
        wait_empty(0, 30);
        chk("t2_pkt_count", pkt_count[0], 3);

        // Output stall pattern 1,0,0,1 during a three-beat packet.
        sel[0] = 2'd1;
        @(posedge clk);
        push(0, 1, 16'h3331, 1'b0);
        push(0, 1, 16'h3332, 1'b0);
        push(0, 1, 16'h3333, 1'b1);
        step();
        step();
        chk("t3_beat1", m_tdata[0], 16'h3331);
        step();
        m_tready[0] = 1'b0;
        step();
        chk("t3_held_dat", m_tdata[0], 16'h3332);
        chk("t3_held_rdy", s_tready[0], 0);
        step();
        chk("t3_held_dat2", m_tdata[0], 16'h3332);
        m_tready[0] = 1'b1;
        wait_empty(0, 30);
        chk("t3_pkt_count", pkt_count[0], 4);

        // Round-robin: all channels offer two-beat packets; ch0 offers two packets.
        @(posedge clk);
        for (int ch = 0; ch < 4; ch++) begin
            push(1, ch, 16'h1000 + 16'(ch), 1'b0);
            push(1, ch, 16'h1000 + 16'(ch), 1'b1);
        end
        push(1, 0, 16'h1000, 1'b0);
        push(1, 0, 16'h1000, 1'b1);
        step();
        for (int p = 0; p < 5; p++) begin
            chk("rr_busy_first", busy[1], 1);
            chk("rr_grant_order", grant[1], p % 4);
            step();
            chk("rr_busy_second", busy[1], 1);
            step();
            chk("rr_idle_gap", busy[1], 0);
            step();
        end
        wait_empty(1, 30);
        chk("rr_pkt_count", pkt_count[1], 5);

        // Reset between beats 2 and 3 of a five-beat packet on channel 2.
        @(posedge clk);
        for (int b = 1; b <= 5; b++) begin
            beat_t sb;
            sb.d = 16'h5550 + 16'(b);
            sb.l = (b == 5);
            src_q[6].push_back(sb);
        end
        exp_q[1].push_back('{d: 16'h5551, l: 1'b0});
        step();
        chk("rst_mid_grant", grant[1], 2);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rst_mid_m_tvalid", m_tvalid[1], 0);
        chk("rst_mid_busy", busy[1], 0);
        chk("rst_mid_pkt_count", pkt_count[1], 0);
        chk("rst_mid_s_tready", s_tready[1], 0);
        chk("rst_mid_scoreboard", exp_q[1].size(), 0);
        src_q[6].delete();
        step();
        step();
        reset = 1'b0;
        @(posedge clk);
        push(1, 0, 16'h6600, 1'b1);
        push(1, 2, 16'h6602, 1'b1);
        step();
        chk("rst_next_grant", grant[1], 0);
        chk("rst_next_busy", busy[1], 1);
        wait_empty(1, 30);
        step();
        chk("rst_next_pkt_count", pkt_count[1], 2);

        chk("oor_m_tvalid_end", m_tvalid2, 0);
        chk("oor_busy_end", busy2, 0);
        chk("oor_s_tready_end", s_tready2, 0);
        chk("oor_pkt_count_end", pkt_count2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
